// File: rtl/hex_pkg.sv
// hex_pkg: shared mode codes, blank pattern and active-low hex glyph table for HEX displays
package hex_pkg;
  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_ADD = 2'b01;
  localparam logic [1:0] MODE_SUB = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [15:0][6:0] GLYPHS = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
  function automatic logic [6:0] glyph(input logic [3:0] n);
    return GLYPHS[n];
  endfunction
endpackage

// File: rtl/hex_to_7seg.sv
// hex_to_7seg: one nibble to active-low {g..a} segments, forced dark when blank is set
module hex_to_7seg
  import hex_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       blank,
  output logic [6:0] seg
);
  assign seg = blank ? SEG_BLANK : glyph(nib);
endmodule

// File: rtl/hex_accum_display.sv
// hex_accum_display: prescaled add/sub/load accumulator with sticky overflow driving HEX digits
module hex_accum_display
  import hex_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DATA_W = 4,
  parameter int DIV = 1,
  parameter int BLANK_LZ = 0,
  localparam int ACC_W = 4 * NUM_DIGITS
) (
  input  logic                    CLOCK_50,
  input  logic                    RESET,
  input  logic [DATA_W-1:0]       SW,
  input  logic [1:0]              MODE,
  input  logic                    EN,
  output logic [ACC_W-1:0]        ACC,
  output logic                    OVF,
  output logic [7*NUM_DIGITS-1:0] HEX
);
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  function automatic logic [7*NUM_DIGITS-1:0] rst_hex();
    for (int i = 0; i < NUM_DIGITS; i++)
      rst_hex[7*i+:7] = (BLANK_LZ != 0 && i > 0) ? SEG_BLANK : glyph(4'h0);
  endfunction
  localparam logic [7*NUM_DIGITS-1:0] RST_HEX = rst_hex();
  logic [CW-1:0] cnt;
  logic tick;
  logic [ACC_W-1:0] opnd;
  logic [ACC_W:0] sum, diff;
  logic [NUM_DIGITS-1:0] blank;
  logic [7*NUM_DIGITS-1:0] seg;
  assign tick = cnt == CW'(DIV - 1);
  assign opnd = ACC_W'(SW);
  assign sum = {1'b0, ACC} + {1'b0, opnd};
  assign diff = {1'b0, ACC} - {1'b0, opnd};
  // free-running prescaler, wraps on the tick cycle
  always_ff @(posedge CLOCK_50 or posedge RESET)
    if (RESET) cnt <= '0;
    else cnt <= tick ? '0 : cnt + 1'b1;
  // accumulator and sticky carry/borrow, updated only on enabled ticks
  always_ff @(posedge CLOCK_50 or posedge RESET)
    if (RESET) begin
      ACC <= '0;
      OVF <= 1'b0;
    end else if (tick && EN) begin
      ACC <= MODE == MODE_HOLD ? ACC : MODE == MODE_ADD ? sum[ACC_W-1:0] :
             MODE == MODE_SUB ? diff[ACC_W-1:0] : opnd;
      OVF <= MODE == MODE_LOAD ? 1'b0 : MODE == MODE_ADD ? OVF | sum[ACC_W] :
             MODE == MODE_SUB ? OVF | diff[ACC_W] : OVF;
    end
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    assign blank[i] = (BLANK_LZ != 0) && (i != 0) && (ACC[ACC_W-1:4*i] == '0);
    hex_to_7seg u_seg (.nib(ACC[4*i+:4]), .blank(blank[i]), .seg(seg[7*i+:7]));
  end
  // display register, one cycle behind the accumulator
  always_ff @(posedge CLOCK_50 or posedge RESET)
    if (RESET) HEX <= RST_HEX;
    else HEX <= seg;
endmodule

// File: tb/tb_hex_accum_display.sv
// tb_hex_accum_display: directed stimulus, arithmetic reference model and literal pins
module tb_hex_accum_display;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0;
  logic [4:0] sw = '0;
  logic [1:0] mode = '0;
  logic [7:0] acc_o[3];
  logic ovf_o[3];
  logic [13:0] hex_o[3];
  int divs[3] = '{4, 4, 1};
  bit blz[3] = '{1'b0, 1'b1, 1'b0};
  logic [6:0] glyphs[16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int m_acc[3], m_n[3];
  bit m_ovf[3];
  logic [13:0] m_hex[3];
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  hex_accum_display #(.NUM_DIGITS(2), .DATA_W(5), .DIV(4), .BLANK_LZ(0)) dut (
    .CLOCK_50(clk), .RESET(rst), .SW(sw), .MODE(mode), .EN(en),
    .ACC(acc_o[0]), .OVF(ovf_o[0]), .HEX(hex_o[0]));
  hex_accum_display #(.NUM_DIGITS(2), .DATA_W(5), .DIV(4), .BLANK_LZ(1)) dut_blz (
    .CLOCK_50(clk), .RESET(rst), .SW(sw), .MODE(mode), .EN(en),
    .ACC(acc_o[1]), .OVF(ovf_o[1]), .HEX(hex_o[1]));
  hex_accum_display #(.NUM_DIGITS(2), .DATA_W(5), .DIV(1), .BLANK_LZ(0)) dut_div1 (
    .CLOCK_50(clk), .RESET(rst), .SW(sw), .MODE(mode), .EN(en),
    .ACC(acc_o[2]), .OVF(ovf_o[2]), .HEX(hex_o[2]));

  function automatic logic [13:0] exp_hex(int a, bit b);
    logic [13:0] h;
    for (int i = 0; i < 2; i++)
      h[7*i+:7] = (b && i > 0 && (a >> (4 * i)) == 0) ? 7'h7F : glyphs[(a >> (4 * i)) & 15];
    return h;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference model: tick when the edge count since reset hits DIV-1 modulo DIV
  always @(posedge clk or posedge rst)
    for (int k = 0; k < 3; k++)
      if (rst) begin
        m_acc[k] = 0;
        m_ovf[k] = 0;
        m_n[k] = 0;
        m_hex[k] = exp_hex(0, blz[k]);
      end else begin
        m_hex[k] = exp_hex(m_acc[k], blz[k]);
        if (m_n[k] % divs[k] == divs[k] - 1 && en)
          case (mode)
            2'd1: begin
              if (m_acc[k] + int'(sw) > 255) m_ovf[k] = 1;
              m_acc[k] = (m_acc[k] + int'(sw)) % 256;
            end
            2'd2: begin
              if (int'(sw) > m_acc[k]) m_ovf[k] = 1;
              m_acc[k] = (m_acc[k] - int'(sw) + 256) % 256;
            end
            2'd3: begin
              m_acc[k] = int'(sw);
              m_ovf[k] = 0;
            end
            default: ;
          endcase
        m_n[k]++;
      end

  // every-cycle comparison against the model
  always @(negedge clk)
    if (!rst)
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("acc%0d", k), 32'(acc_o[k]), 32'(m_acc[k]));
        chk($sformatf("ovf%0d", k), 32'(ovf_o[k]), 32'(m_ovf[k]));
        chk($sformatf("hex%0d", k), 32'(hex_o[k]), 32'(m_hex[k]));
      end

  task automatic op(logic [1:0] m, logic [4:0] s);
    mode = m;
    sw = s;
    en = 1'b1;
    repeat (4) @(posedge clk);
    #1 en = 1'b0;
  endtask

  initial begin
    #12;
    chk("rst_acc", 32'(acc_o[0]), 32'h0);
    chk("rst_hex", 32'(hex_o[0]), 32'h2040);
    chk("rst_hex_blz", 32'(hex_o[1]), 32'h3FC0);
    @(posedge clk);
    #1 rst = 1'b0;
    mode = 2'd3;
    sw = 5'h1A;
    en = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("load_pre_tick", 32'(acc_o[0]), 32'h0);
    @(posedge clk);
    #1 chk("load_at_tick", 32'(acc_o[0]), 32'h1A);
    en = 1'b0;
    @(posedge clk);
    #1 chk("hex_1a", 32'(hex_o[0]), 32'({7'h79, 7'h08}));
    op(2'd3, 5'h1E);
    repeat (7) op(2'd1, 5'h1E);
    chk("acc_f0", 32'(acc_o[0]), 32'hF0);
    chk("ovf_f0", 32'(ovf_o[0]), 32'h0);
    op(2'd1, 5'h10);
    chk("wrap_exact_acc", 32'(acc_o[0]), 32'h00);
    chk("wrap_exact_ovf", 32'(ovf_o[0]), 32'h1);
    op(2'd3, 5'h1E);
    repeat (7) op(2'd1, 5'h1E);
    op(2'd1, 5'h1F);
    chk("add_carry_acc", 32'(acc_o[0]), 32'h0F);
    chk("add_carry_ovf", 32'(ovf_o[0]), 32'h1);
    op(2'd3, 5'h03);
    chk("load3_acc", 32'(acc_o[0]), 32'h03);
    chk("load3_ovf", 32'(ovf_o[0]), 32'h0);
    op(2'd3, 5'h02);
    op(2'd2, 5'h05);
    chk("sub_borrow_acc", 32'(acc_o[0]), 32'hFD);
    chk("sub_borrow_ovf", 32'(ovf_o[0]), 32'h1);
    op(2'd1, 5'h01);
    chk("sticky_acc", 32'(acc_o[0]), 32'hFE);
    chk("sticky_ovf", 32'(ovf_o[0]), 32'h1);
    op(2'd3, 5'h01);
    op(2'd2, 5'h01);
    chk("sub_equal_acc", 32'(acc_o[0]), 32'h0);
    chk("sub_equal_ovf", 32'(ovf_o[0]), 32'h0);
    op(2'd3, 5'h05);
    mode = 2'd1;
    repeat (16) begin
      @(posedge clk);
      #1 sw = sw ^ 5'h1F;
    end
    chk("en0_hold", 32'(acc_o[0]), 32'h05);
    chk("en0_hold_div1", 32'(acc_o[2]), 32'h05);
    mode = 2'd0;
    en = 1'b1;
    repeat (16) begin
      @(posedge clk);
      #1 sw = sw ^ 5'h1F;
    end
    chk("mode_hold", 32'(acc_o[0]), 32'h05);
    mode = 2'd1;
    sw = 5'h01;
    repeat (16) @(posedge clk);
    #1 en = 1'b0;
    chk("tick_every4", 32'(acc_o[0]), 32'h09);
    chk("tick_every1", 32'(acc_o[2]), 32'h15);
    op(2'd3, 5'h05);
    @(posedge clk);
    #1 chk("blz_05", 32'(hex_o[1]), 32'({7'h7F, 7'h12}));
    chk("noblz_05", 32'(hex_o[0]), 32'({7'h40, 7'h12}));
    op(2'd3, 5'h00);
    @(posedge clk);
    #1 chk("blz_00", 32'(hex_o[1]), 32'({7'h7F, 7'h40}));
    op(2'd3, 5'h10);
    @(posedge clk);
    #1 chk("blz_10", 32'(hex_o[1]), 32'({7'h79, 7'h40}));
    mode = 2'd1;
    sw = 5'h03;
    en = 1'b1;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("async_acc%0d", k), 32'(acc_o[k]), 32'h0);
      chk($sformatf("async_ovf%0d", k), 32'(ovf_o[k]), 32'h0);
    end
    chk("async_hex", 32'(hex_o[0]), 32'({7'h40, 7'h40}));
    chk("async_hex_blz", 32'(hex_o[1]), 32'({7'h7F, 7'h40}));
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (8) @(posedge clk);
    #1 en = 1'b0;
    chk("post_rst_add", 32'(acc_o[0]), 32'h06);
    repeat (2) @(posedge clk);
    #1 $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
